// File: rtl/risc16_pkg.sv
// Shared RISC16 definitions for the LM/SM expansion logic: opcodes, sequencer
// state encoding and the mask-bit to register-index mapping.
package risc16_pkg;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } lmsm_state_e;

  // Mask bit 7 selects R0 and mask bit 0 selects R7.
  function automatic logic [2:0] mask_bit_to_reg(input logic [2:0] bit_pos);
    return 3'd7 - bit_pos;
  endfunction

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Micro-op bus between the LM/SM sequencer (master) and the ID/RR register (slave).
interface lmsm_sequencer_if #(
  parameter int OFFS_W = 16
) ();

  logic              uop_valid;
  logic              uop_ready;
  logic              uop_is_load;
  logic [2:0]        uop_base;
  logic [2:0]        uop_reg;
  logic [OFFS_W-1:0] uop_offset;
  logic              uop_last;

  modport master (
    output uop_valid, uop_is_load, uop_base, uop_reg, uop_offset, uop_last,
    input  uop_ready
  );

  modport slave (
    input  uop_valid, uop_is_load, uop_base, uop_reg, uop_offset, uop_last,
    output uop_ready
  );

endinterface

// File: rtl/lmsm_prio_enc.sv
// Combinational 8-bit priority encoder over an LM/SM register mask: finds the
// lowest-numbered register still pending, its one-hot clear vector and a
// "exactly one bit left" flag.
module lmsm_prio_enc
  import risc16_pkg::*;
(
  input  logic [7:0] mask,
  output logic [2:0] reg_idx,
  output logic [7:0] clr_vec,
  output logic       single
);

  // Highest set mask bit wins, since it corresponds to the lowest register.
  always_comb begin
    reg_idx = 3'd0;
    clr_vec = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        reg_idx = mask_bit_to_reg(3'(i));
        clr_vec = 8'h01 << i;
      end else begin
        reg_idx = reg_idx;
        clr_vec = clr_vec;
      end
    end
  end

  // Power-of-two test: exactly one register remains.
  always_comb begin
    single = (mask != 8'h00) && ((mask & (mask - 8'd1)) == 8'h00);
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: expands a multiple load/store in ID into one micro-op per set
// mask bit, holding IF/ID meanwhile. Optional LMSM_PERF_CNT_EN adds counters.
module lmsm_sequencer
  import risc16_pkg::*;
#(
  parameter int ADDR_STEP = 1,
  parameter int OFFS_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_ir,
  input  logic        id_valid,
  input  logic        flush,
  output logic        id_bubble,
  output logic        id_hold,
  output logic        busy,
`ifdef LMSM_PERF_CNT_EN
  output logic [15:0] perf_uops,
  output logic [15:0] perf_hold,
`endif
  lmsm_sequencer_if.master uop
);

  lmsm_state_e       state_r;
  logic [7:0]        mask_r;
  logic [2:0]        base_r;
  logic              is_load_r;
  logic [OFFS_W-1:0] offset_r;

  logic [3:0] opcode_s;
  logic       detect_s;
  logic       in_issue_s;
  logic       accept_s;
  logic [2:0] reg_idx_s;
  logic [7:0] clr_vec_s;
  logic       single_s;
  logic       unused_ok_s;

  assign opcode_s    = id_ir[15:12];
  assign detect_s    = id_valid & ((opcode_s == OP_LM) | (opcode_s == OP_SM))
                     & (state_r == IDLE) & ~flush;
  // Outputs are forced low for as long as rst is asserted.
  assign in_issue_s  = (state_r == ISSUE) & ~rst;
  assign accept_s    = in_issue_s & uop.uop_ready;
  assign unused_ok_s = id_ir[8];

  lmsm_prio_enc u_prio_enc (
    .mask    (mask_r),
    .reg_idx (reg_idx_s),
    .clr_vec (clr_vec_s),
    .single  (single_s)
  );

  assign id_bubble       = detect_s & ~rst;
  assign id_hold         = in_issue_s;
  assign busy            = in_issue_s;
  assign uop.uop_valid   = in_issue_s;
  assign uop.uop_is_load = in_issue_s & is_load_r;
  assign uop.uop_base    = in_issue_s ? base_r : 3'd0;
  assign uop.uop_reg     = in_issue_s ? reg_idx_s : 3'd0;
  assign uop.uop_offset  = in_issue_s ? offset_r : {OFFS_W{1'b0}};
  assign uop.uop_last    = in_issue_s & single_s;

  // Sequencer FSM: latch LM/SM on detect, retire one mask bit per accepted element.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      mask_r    <= 8'h00;
      base_r    <= 3'd0;
      is_load_r <= 1'b0;
      offset_r  <= {OFFS_W{1'b0}};
    end else if (flush) begin
      state_r  <= IDLE;
      mask_r   <= 8'h00;
      offset_r <= {OFFS_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // A zero mask retires as a NOP without leaving IDLE.
          if (detect_s && (id_ir[7:0] != 8'h00)) begin
            state_r   <= ISSUE;
            mask_r    <= id_ir[7:0];
            base_r    <= id_ir[11:9];
            is_load_r <= (opcode_s == OP_LM);
            offset_r  <= {OFFS_W{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (uop.uop_ready) begin
            mask_r   <= mask_r & ~clr_vec_s;
            offset_r <= offset_r + OFFS_W'(ADDR_STEP);
            state_r  <= single_s ? IDLE : ISSUE;
          end else begin
            state_r <= ISSUE;
          end
        end
        default: begin
          state_r <= IDLE;
          mask_r  <= 8'h00;
        end
      endcase
    end
  end

`ifdef LMSM_PERF_CNT_EN
  logic [15:0] perf_uops_r;
  logic [15:0] perf_hold_r;

  // Saturating event counters; flush does not touch them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_uops_r <= 16'd0;
      perf_hold_r <= 16'd0;
    end else begin
      if (accept_s && (perf_uops_r != 16'hFFFF)) begin
        perf_uops_r <= perf_uops_r + 16'd1;
      end else begin
        perf_uops_r <= perf_uops_r;
      end
      if (in_issue_s && (perf_hold_r != 16'hFFFF)) begin
        perf_hold_r <= perf_hold_r + 16'd1;
      end else begin
        perf_hold_r <= perf_hold_r;
      end
    end
  end

  assign perf_uops = perf_uops_r;
  assign perf_hold = perf_hold_r;
`endif

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: expected micro-ops are queued when an
// LM/SM is driven and compared as the DUT hands each element over.
module tb_lmsm_sequencer;
  import risc16_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id_ir;
  logic        id_valid;
  logic        flush;
  logic        id_bubble;
  logic        id_hold;
  logic        busy;
`ifdef LMSM_PERF_CNT_EN
  logic [15:0] perf_uops;
  logic [15:0] perf_hold;
`endif

  lmsm_sequencer_if #(.OFFS_W(16)) uop ();

  lmsm_sequencer #(.ADDR_STEP(1), .OFFS_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_ir     (id_ir),
    .id_valid  (id_valid),
    .flush     (flush),
    .id_bubble (id_bubble),
    .id_hold   (id_hold),
    .busy      (busy),
`ifdef LMSM_PERF_CNT_EN
    .perf_uops (perf_uops),
    .perf_hold (perf_hold),
`endif
    .uop       (uop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_load;
    logic [2:0]  base;
    logic [2:0]  rg;
    logic [15:0] offset;
    logic        last;
  } uop_t;

  uop_t exp_q[$];
  int   pass_cnt  = 0;
  int   chk_cnt   = 0;
  int   hold_cnt  = 0;
  int   bubble_cnt = 0;
  int   valid_cnt = 0;
  logic stall_prev = 1'b0;
  logic alt_ready  = 1'b0;
  uop_t snap;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic uop_t cur_uop();
    uop_t u;
    u = {uop.uop_is_load, uop.uop_base, uop.uop_reg, uop.uop_offset, uop.uop_last};
    return u;
  endfunction

  // Independent model: registers in R0..R7 order, offsets counting from 0.
  task automatic push_elems(input logic ld, input logic [2:0] base, input logic [7:0] mask,
                            input int n);
    int   total = 0;
    int   k = 0;
    uop_t e;
    for (int b = 0; b < 8; b++) if (mask[b]) total++;
    for (int r = 0; r < 8; r++) begin
      if (mask[7-r]) begin
        if (k < n) begin
          e.is_load = ld;
          e.base    = base;
          e.rg      = 3'(r);
          e.offset  = 16'(k);
          e.last    = (k == total - 1);
          exp_q.push_back(e);
        end
        k++;
      end
    end
  endtask

  task automatic sample();
    uop_t e;
    @(negedge clk);
    if (id_hold) hold_cnt++;
    if (id_bubble) bubble_cnt++;
    if (stall_prev) begin
      check_val("stall_valid", uop.uop_valid, 1);
      check_val("stall_stable", cur_uop(), snap);
    end
    if (uop.uop_valid) begin
      valid_cnt++;
      if (uop.uop_ready) begin
        if (exp_q.size() == 0) check_val("sb_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_val("uop", cur_uop(), e);
        end
      end
    end
    stall_prev = uop.uop_valid & ~uop.uop_ready & ~flush & ~rst;
    snap = cur_uop();
  endtask

  task automatic cycle();
    sample();
    @(posedge clk);
    #1;
    if (alt_ready) uop.uop_ready = ~uop.uop_ready;
  endtask

  task automatic clear_counts();
    hold_cnt = 0;
    bubble_cnt = 0;
    valid_cnt = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 64) begin
      cycle();
      n++;
    end
    check_val(tag, (n < 64), 1);
  endtask

  task automatic run_lmsm(input logic is_lm, input logic [2:0] base, input logic [7:0] mask,
                          input int n_push, input logic alt);
    clear_counts();
    id_ir = {(is_lm ? OP_LM : OP_SM), base, 1'b0, mask};
    id_valid = 1'b1;
    uop.uop_ready = 1'b1;
    push_elems(is_lm, base, mask, n_push);
    #1;
    check_val("detect_bubble", id_bubble, 1);
    cycle();
    id_valid = 1'b0;
    id_ir = 16'h0000;
    uop.uop_ready = ~alt;
    alt_ready = alt;
    #1;
    wait_idle("issue_timeout");
    alt_ready = 1'b0;
    uop.uop_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    id_ir = 16'h0000;
    id_valid = 1'b0;
    flush = 1'b0;
    uop.uop_ready = 1'b1;
    cycle();
    cycle();
    id_ir = {OP_LM, 3'd1, 1'b0, 8'hFF};
    id_valid = 1'b1;
    #1;
    check_val("rst_outputs", {id_bubble, id_hold, busy, uop.uop_valid, uop.uop_last}, 0);
    cycle();
    rst = 1'b0;
    id_valid = 1'b0;
    #1;
    check_val("post_rst_busy", busy, 0);

    // LM R2, mask A1 -> R0/0, R2/1, R7/2 last; three hold cycles.
    run_lmsm(1'b1, 3'd2, 8'hA1, 8, 1'b0);
    check_val("t1_hold", hold_cnt, 3);
    check_val("t1_drain", exp_q.size(), 0);
    check_val("t1_hold_drop", id_hold, 0);

    // SM mask FF with ready low every other cycle: 16 ISSUE cycles.
    run_lmsm(1'b0, 3'd5, 8'hFF, 8, 1'b1);
    check_val("t2_hold", hold_cnt, 16);
    check_val("t2_drain", exp_q.size(), 0);

    // Zero mask: single bubble, nothing issued.
    run_lmsm(1'b1, 3'd3, 8'h00, 8, 1'b0);
    cycle();
    cycle();
    check_val("t3_bubble", bubble_cnt, 1);
    check_val("t3_valid", valid_cnt, 0);
    check_val("t3_hold", hold_cnt, 0);

    // Flush in the 2nd ISSUE cycle of mask F0: only R0 and R1 emerge.
    clear_counts();
    id_ir = {OP_LM, 3'd1, 1'b0, 8'hF0};
    id_valid = 1'b1;
    push_elems(1'b1, 3'd1, 8'hF0, 2);
    cycle();
    id_valid = 1'b0;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    check_val("t4_busy", busy, 0);
    check_val("t4_valid", uop.uop_valid, 0);
    cycle();
    check_val("t4_drain", exp_q.size(), 0);
    run_lmsm(1'b1, 3'd6, 8'h18, 8, 1'b0);
    check_val("t4_after_drain", exp_q.size(), 0);

    // Reset pulse mid-ISSUE, then restart from offset 0.
    id_ir = {OP_LM, 3'd4, 1'b0, 8'h0F};
    id_valid = 1'b1;
    push_elems(1'b1, 3'd4, 8'h0F, 1);
    cycle();
    id_valid = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    check_val("t5_rst_outputs", {id_bubble, id_hold, busy, uop.uop_valid, uop.uop_last,
              uop.uop_reg, uop.uop_offset}, 0);
    cycle();
    rst = 1'b0;
    #1;
    check_val("t5_idle_busy", busy, 0);
    check_val("t5_idle_valid", uop.uop_valid, 0);
    check_val("t5_drain", exp_q.size(), 0);
    run_lmsm(1'b1, 3'd4, 8'h0F, 8, 1'b0);
    check_val("t5_restart_drain", exp_q.size(), 0);

    // Back-to-back LMs (masks 80 then 01) after a reset to zero the counters.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_counts();
    id_ir = {OP_LM, 3'd0, 1'b0, 8'h80};
    id_valid = 1'b1;
    push_elems(1'b1, 3'd0, 8'h80, 8);
    push_elems(1'b1, 3'd0, 8'h01, 8);
    cycle();
    id_ir = {OP_LM, 3'd0, 1'b0, 8'h01};
    #1;
    check_val("t6_hold_first", id_hold, 1);
    check_val("t6_no_bubble", id_bubble, 0);
    cycle();
    #1;
    check_val("t6_gap_busy", busy, 0);
    check_val("t6_second_detect", id_bubble, 1);
    cycle();
    id_valid = 1'b0;
    #1;
    check_val("t6_second_valid", uop.uop_valid, 1);
    wait_idle("t6_timeout");
    check_val("t6_drain", exp_q.size(), 0);
    check_val("t6_valid_cnt", valid_cnt, 2);
`ifdef LMSM_PERF_CNT_EN
    check_val("t6_perf_uops", perf_uops, 2);
    check_val("t6_perf_hold", perf_hold, 2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
